// File: rtl/uart_rx_frame_ctrl.sv
// Byte-stream framer for a UART receiver: SYNC, ADDR, LEN, payload, XOR checksum.
// A checked frame is held for the consumer until frame_ack, with registered error pulses.
module uart_rx_frame_ctrl #(
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int          MAX_LEN      = 8,
   parameter logic [15:0] TIMEOUT_CLKS = 16'd2000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       data_ready,
   input  logic [7:0] rxdata,
   input  logic       frame_ack,
   input  logic [2:0] rd_idx,
   output logic [7:0] rd_data,
   output logic       frame_valid,
   output logic [7:0] frame_addr,
   output logic [3:0] frame_len,
   output logic       err_csum,
   output logic       err_len,
   output logic       err_timeout,
   output logic       err_overrun
);

   typedef enum logic [2:0] {IDLE, ADDR, LEN, PAYLOAD, CSUM, HOLD} state_t;

   localparam logic [15:0] TERM_CNT  = TIMEOUT_CLKS - 16'd1;
   localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [2:0]  r_idx;
   logic [7:0]  r_csum;
   logic [7:0]  r_addr;
   logic [3:0]  r_len;
   logic        r_valid;
   logic        r_err_csum;
   logic        r_err_len;
   logic        r_err_timeout;
   logic        r_err_overrun;
   logic [7:0]  r_buf [8];

   logic        w_last_byte;

   assign w_last_byte = ({1'b0, r_idx} == (r_len - 4'd1));

   // NOTE: all state here is updated with non-blocking assignments so every
   // register samples pre-edge values; blocking '=' would create ordering bugs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_idx         <= '0;
         r_csum        <= '0;
         r_addr        <= '0;
         r_len         <= '0;
         r_valid       <= 1'b0;
         r_err_csum    <= 1'b0;
         r_err_len     <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_overrun <= 1'b0;
         // NOTE: the payload buffer is small and must read back as zero after
         // reset, so it is built from flops with reset rather than a RAM.
         for (int i = 0; i < 8; i++) r_buf[i] <= '0;
      end else begin
         r_err_csum    <= 1'b0;
         r_err_len     <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_overrun <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (data_ready && rxdata == SYNC_BYTE) r_state <= ADDR;
            end
            HOLD: begin
               r_cnt <= '0;
               if (data_ready) r_err_overrun <= 1'b1;
               if (frame_ack) begin
                  r_valid <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               // A byte on the terminal-count cycle wins over the timeout.
               if (data_ready) begin
                  r_cnt <= '0;
                  case (r_state)
                     ADDR: begin
                        r_addr  <= rxdata;
                        r_csum  <= rxdata;
                        r_state <= LEN;
                     end
                     LEN: begin
                        if (rxdata == 8'd0 || rxdata > MAX_LEN_B) begin
                           r_err_len <= 1'b1;
                           r_state   <= IDLE;
                        end else begin
                           r_len   <= rxdata[3:0];
                           r_csum  <= r_csum ^ rxdata;
                           r_idx   <= '0;
                           r_state <= PAYLOAD;
                        end
                     end
                     PAYLOAD: begin
                        r_buf[r_idx] <= rxdata;
                        r_csum       <= r_csum ^ rxdata;
                        r_idx        <= r_idx + 3'd1;
                        if (w_last_byte) r_state <= CSUM;
                     end
                     CSUM: begin
                        if (rxdata == r_csum) begin
                           r_valid <= 1'b1;
                           r_state <= HOLD;
                        end else begin
                           r_err_csum <= 1'b1;
                           r_state    <= IDLE;
                        end
                     end
                     default: r_state <= IDLE;
                  endcase
               end else if (r_cnt == TERM_CNT) begin
                  r_err_timeout <= 1'b1;
                  r_cnt         <= '0;
                  r_state       <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
         endcase
      end
   end

   assign rd_data     = r_buf[rd_idx];
   assign frame_valid = r_valid;
   assign frame_addr  = r_addr;
   assign frame_len   = r_len;
   assign err_csum    = r_err_csum;
   assign err_len     = r_err_len;
   assign err_timeout = r_err_timeout;
   assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: expected frames/errors are queued as
// stimulus is driven and matched against DUT events seen on the falling edge.
module tb_uart_rx_frame_ctrl;

   localparam logic [15:0] TO = 16'd20;

   typedef enum int {EV_NONE, EV_FRAME, EV_CSUM, EV_LEN, EV_TO, EV_OVR} ev_t;
   typedef logic [7:0] pl_t [8];
   typedef struct {
      ev_t        kind;
      logic [7:0] addr;
      logic [3:0] len;
      pl_t        pl;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       data_ready = 1'b0;
   logic [7:0] rxdata = 8'h00;
   logic       frame_ack = 1'b0;
   logic [2:0] rd_idx = 3'd0;
   logic [7:0] rd_data;
   logic       frame_valid;
   logic [7:0] frame_addr;
   logic [3:0] frame_len;
   logic       err_csum, err_len, err_timeout, err_overrun;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   uart_rx_frame_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(8), .TIMEOUT_CLKS(TO)) dut (
      .clk(clk), .rst_n(rst_n), .data_ready(data_ready), .rxdata(rxdata),
      .frame_ack(frame_ack), .rd_idx(rd_idx), .rd_data(rd_data),
      .frame_valid(frame_valid), .frame_addr(frame_addr), .frame_len(frame_len),
      .err_csum(err_csum), .err_len(err_len), .err_timeout(err_timeout),
      .err_overrun(err_overrun)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_ev(input ev_t k);
      exp_t e;
      e.kind = k;
      e.addr = '0;
      e.len  = '0;
      for (int i = 0; i < 8; i++) e.pl[i] = '0;
      q.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      data_ready = 1'b1;
      rxdata     = b;
      @(negedge clk);
      data_ready = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] addr, input logic [7:0] len,
                             input pl_t pl, input bit bad_csum);
      exp_t       e;
      logic [7:0] cs;
      cs = addr ^ len;
      for (int i = 0; i < int'(len); i++) cs = cs ^ pl[i];
      e.kind = bad_csum ? EV_CSUM : EV_FRAME;
      e.addr = addr;
      e.len  = len[3:0];
      e.pl   = pl;
      q.push_back(e);
      send_byte(8'hA5);
      send_byte(addr);
      send_byte(len);
      for (int i = 0; i < int'(len); i++) send_byte(pl[i]);
      send_byte(bad_csum ? (cs ^ 8'h01) : cs);
   endtask

   task automatic do_ack(input string tag);
      @(negedge clk);
      frame_ack = 1'b1;
      @(negedge clk);
      frame_ack = 1'b0;
      check(tag, 32'(frame_valid), 32'd0);
   endtask

   // Monitor: turns DUT outputs into events and pops the scoreboard.
   initial begin : monitor
      logic prev_v;
      ev_t  obs;
      exp_t e;
      int   npulse;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         npulse = int'(err_csum) + int'(err_len) + int'(err_timeout) + int'(err_overrun);
         obs = EV_NONE;
         if (err_csum)                     obs = EV_CSUM;
         else if (err_len)                 obs = EV_LEN;
         else if (err_timeout)             obs = EV_TO;
         else if (err_overrun)             obs = EV_OVR;
         else if (frame_valid && !prev_v)  obs = EV_FRAME;
         prev_v = frame_valid;
         if (npulse > 1) check("one_pulse_per_cycle", 32'(npulse), 32'd1);
         if (obs != EV_NONE) begin
            if (q.size() == 0) begin
               check("unexpected_event", 32'(obs), 32'(EV_NONE));
            end else begin
               e = q.pop_front();
               check("event_kind", 32'(obs), 32'(e.kind));
               if (obs == EV_FRAME && e.kind == EV_FRAME) begin
                  check("frame_addr", 32'(frame_addr), 32'(e.addr));
                  check("frame_len", 32'(frame_len), 32'(e.len));
                  for (int i = 0; i < int'(e.len); i++) begin
                     rd_idx = 3'(i);
                     #1;
                     check("payload", 32'(rd_data), 32'(e.pl[i]));
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      pl_t p;
      int  cnt;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(frame_valid), 32'd0);
      check("rst_addr", 32'(frame_addr), 32'd0);
      check("rst_len", 32'(frame_len), 32'd0);
      check("rst_errs", 32'({err_csum, err_len, err_timeout, err_overrun}), 32'd0);
      check("rst_buf", 32'(rd_data), 32'd0);
      rst_n = 1'b1;

      // Junk bytes in IDLE are dropped silently; ack outside HOLD is ignored
      send_byte(8'h33);
      send_byte(8'h10);
      send_byte(8'h00);
      do_ack("ack_in_idle");

      // Basic frame: A5,10,02,11,22,21
      p = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(8'h10, 8'h02, p, 1'b0);
      check("valid_latency", 32'(frame_valid), 32'd1);
      idle(3);
      check("hold_stable", 32'(frame_valid), 32'd1);
      do_ack("ack_release");

      // Same frame with checksum 20
      send_frame(8'h10, 8'h02, p, 1'b1);
      check("csum_no_valid", 32'(frame_valid), 32'd0);

      // Length errors
      push_ev(EV_LEN);
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00);
      push_ev(EV_LEN);
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h09);
      check("len_no_valid", 32'(frame_valid), 32'd0);

      // Max length with SYNC values inside the frame treated as data
      p = '{8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      send_frame(8'hA5, 8'h08, p, 1'b0);
      check("maxlen_valid", 32'(frame_valid), 32'd1);
      do_ack("maxlen_ack");

      // Timeout after a partial frame
      push_ev(EV_TO);
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11);
      cnt = 0;
      while (!err_timeout && cnt < 3 * int'(TO)) begin
         @(negedge clk);
         cnt++;
      end
      check("timeout_cycles", 32'(cnt), 32'(TO));
      p = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(8'h20, 8'h01, p, 1'b0);
      check("after_timeout_valid", 32'(frame_valid), 32'd1);
      do_ack("after_timeout_ack");

      // Every byte arrives exactly on the terminal-count cycle: byte wins
      p = '{8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      begin
         exp_t e;
         e.kind = EV_FRAME; e.addr = 8'h30; e.len = 4'd1; e.pl = p;
         q.push_back(e);
      end
      send_byte(8'hA5); idle(int'(TO) - 2);
      send_byte(8'h30); idle(int'(TO) - 2);
      send_byte(8'h01); idle(int'(TO) - 2);
      send_byte(8'h44); idle(int'(TO) - 2);
      send_byte(8'h30 ^ 8'h01 ^ 8'h44);
      check("edge_valid", 32'(frame_valid), 32'd1);
      do_ack("edge_ack");

      // Overrun in HOLD, then ack coinciding with a byte
      p = '{8'hC1, 8'hC2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(8'h50, 8'h03, p, 1'b0);
      push_ev(EV_OVR);
      send_byte(8'h77);
      check("ovr_valid_kept", 32'(frame_valid), 32'd1);
      check("ovr_addr_kept", 32'(frame_addr), 32'h50);
      check("ovr_len_kept", 32'(frame_len), 32'd3);
      check("ovr_buf_kept", 32'(rd_data), 32'hC3);
      push_ev(EV_OVR);
      @(negedge clk);
      data_ready = 1'b1;
      rxdata     = 8'h88;
      frame_ack  = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      frame_ack  = 1'b0;
      check("ack_with_byte", 32'(frame_valid), 32'd0);

      // Reset during PAYLOAD
      send_byte(8'hA5); send_byte(8'h60); send_byte(8'h04);
      send_byte(8'h01); send_byte(8'h02);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(frame_valid), 32'd0);
      check("midrst_addr", 32'(frame_addr), 32'd0);
      check("midrst_len", 32'(frame_len), 32'd0);
      check("midrst_buf", 32'(rd_data), 32'd0);
      idle(2);
      check("midrst_errs", 32'({err_csum, err_len, err_timeout, err_overrun}), 32'd0);
      rst_n = 1'b1;
      p = '{8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(8'h61, 8'h02, p, 1'b0);
      check("postrst_valid", 32'(frame_valid), 32'd1);
      do_ack("postrst_ack");

      cnt = 0;
      while (q.size() != 0 && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      check("scoreboard_drained", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
